// File: rtl/board_reset_controller_pkg.sv
// rtl/board_reset_controller_pkg.sv - shared state encodings for the board reset sequencer
package board_reset_controller_pkg;

  // Raw encodings kept as plain localparams so other board tops and benches can reuse them
  localparam logic [1:0] STATE_HOLD         = 2'd0;
  localparam logic [1:0] STATE_WAIT_RELEASE = 2'd1;
  localparam logic [1:0] STATE_RUN          = 2'd2;

  typedef enum logic [1:0] {
    HOLD         = STATE_HOLD,
    WAIT_RELEASE = STATE_WAIT_RELEASE,
    RUN          = STATE_RUN
  } brc_state_e;

endpackage

// File: rtl/debounce_filter.sv
// rtl/debounce_filter.sv - two-flop synchronizer followed by a consecutive-cycle stability filter
module debounce_filter #(
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] count;

  // Synchronize, then accept a new level only after it has disagreed for DEBOUNCE_CYCLES in a row
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      count  <= '0;
      stable <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 != stable) begin
        if (count == LAST) begin
          stable <= sync2;
          count  <= '0;
        end else begin
          count <= count + CW'(1);
        end
      end else begin
        count <= '0;
      end
    end
  end

endmodule

// File: rtl/board_reset_controller.sv
// rtl/board_reset_controller.sv - debounced reset/halt sequencer driving the core reset_n and halt pins
module board_reset_controller
  import board_reset_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 120000,
  parameter int RESET_HOLD_CYCLES = 16,
  parameter int COUNT_WIDTH       = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   button_raw,
  input  logic                   halt_raw,
  output logic                   core_reset_n,
  output logic                   core_halt,
  output logic [COUNT_WIDTH-1:0] reset_count,
  output logic                   in_reset
);

  localparam int HW = $clog2(RESET_HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD_CYCLES - 1);

  logic          button_stable;
  logic          halt_stable;
  brc_state_e    state_q;
  brc_state_e    state_d;
  logic [HW-1:0] hold_q;
  logic [HW-1:0] hold_d;
  logic          count_inc;

  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_button_filter (
    .clock  (clock),
    .reset  (reset),
    .raw    (button_raw),
    .stable (button_stable)
  );

  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_halt_filter (
    .clock  (clock),
    .reset  (reset),
    .raw    (halt_raw),
    .stable (halt_stable)
  );

  // Next-state logic: a held button always parks in WAIT_RELEASE; leaving it restarts a full hold
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    count_inc = 1'b0;
    case (state_q)
      HOLD: begin
        if (button_stable) begin
          state_d = WAIT_RELEASE;
          hold_d  = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = RUN;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      WAIT_RELEASE: begin
        hold_d = '0;
        if (!button_stable) state_d = HOLD;
      end
      RUN: begin
        hold_d = '0;
        // RUN is only entered with the button released, so a high level here is a fresh press
        if (button_stable) begin
          state_d   = WAIT_RELEASE;
          count_inc = 1'b1;
        end
      end
      default: begin
        state_d = HOLD;
        hold_d  = '0;
      end
    endcase
  end

  // State, press counter and registered outputs; outputs follow the next state so nothing is combinational
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= HOLD;
      hold_q       <= '0;
      reset_count  <= '0;
      core_reset_n <= 1'b0;
      in_reset     <= 1'b1;
      core_halt    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      if (count_inc && (reset_count != '1)) reset_count <= reset_count + COUNT_WIDTH'(1);
      core_reset_n <= (state_d == RUN);
      in_reset     <= (state_d != RUN);
      core_halt    <= halt_stable && (state_d == RUN);
    end
  end

endmodule
